// File: rtl/vector_pkg.sv
// Shared types for the vector display sequencer:
// DAC channel codes, FSM states and command sizing.
package vector_pkg;

    localparam logic [1:0] CH_X = 2'd0;
    localparam logic [1:0] CH_Y = 2'd1;
    localparam logic [1:0] CH_Z = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STEP,
        S_OUT_X,
        S_OUT_Y,
        S_OUT_Z,
        S_DWELL
    } state_e;

    // Packed command is {x, y, bright}.
    function automatic int cmd_width(int bits);
        return 2 * bits + 1;
    endfunction

endpackage

// File: rtl/vector_sequencer_if.sv
// Command intake and DAC write bundle of the vector sequencer.
// The slave side is the sequencer, the master side drives it.
interface vector_sequencer_if #(
    parameter int BITS       = 12,
    parameter int FIFO_DEPTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic [BITS-1:0]             in_x;
    logic [BITS-1:0]             in_y;
    logic                        in_bright;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;
    logic                        busy;
    logic [BITS-1:0]             dac_value;
    logic [1:0]                  dac_channel;
    logic                        dac_strobe;
    logic                        dac_ready;

    modport master (
        output in_valid, in_x, in_y, in_bright, dac_ready,
        input  in_ready, fifo_level, busy,
        input  dac_value, dac_channel, dac_strobe
    );

    modport slave (
        input  in_valid, in_x, in_y, in_bright, dac_ready,
        output in_ready, fifo_level, busy,
        output dac_value, dac_channel, dac_strobe
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; a word written in one cycle
// is readable the next. Writes when full are dropped.
module sync_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [AW:0]      level_q, level_d;
    logic             wr_ok, rd_ok;

    assign full    = (level_q == (AW+1)'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rptr_q];
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        level_d = level_q;
        if (wr_ok) wptr_d = wptr_q + 1'b1;
        if (rd_ok) rptr_d = rptr_q + 1'b1;
        if (wr_ok && !rd_ok) level_d = level_q + 1'b1;
        if (rd_ok && !wr_ok) level_d = level_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            level_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= wr_data;
    end

endmodule

// File: rtl/vector_sequencer.sv
// Buffers draw commands, walks a Bresenham line to each target
// and streams every point to the DAC driver as X, Y [, Z] writes.
module vector_sequencer
    import vector_pkg::*;
#(
    parameter int BITS       = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int CHANNELS   = 2,
    parameter int DWELL      = 0
) (
    input  logic              clk,
    input  logic              reset,
    vector_sequencer_if.slave bus
);

    localparam int W  = BITS + 2;
    localparam int LW = $clog2(FIFO_DEPTH) + 1;

    typedef struct packed {
        logic [BITS-1:0] x;
        logic [BITS-1:0] y;
        logic            bright;
    } cmd_t;

    cmd_t          wr_cmd, rd_cmd;
    logic          full, empty, pop;
    logic [LW-1:0] level;

    state_e          state_q, state_d;
    logic [BITS-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [BITS-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [BITS-1:0] dx_q, dx_d, dy_q, dy_d;
    logic            sx_q, sx_d, sy_q, sy_d;
    logic            bright_q, bright_d;
    logic signed [W-1:0] err_q, err_d;
    logic [15:0]     dwell_q, dwell_d;
    logic [BITS-1:0] val_q, val_d;
    logic [1:0]      ch_q, ch_d;
    logic            stb_q, stb_d;

    logic [BITS-1:0] dx_n, dy_n;
    logic signed [W:0] e2, dxe, dye, err_w;
    logic            at_end, can_out;
    state_e          seg_next;

    assign wr_cmd = '{x: bus.in_x, y: bus.in_y, bright: bus.in_bright};

    sync_fifo #(
        .WIDTH(cmd_width(BITS)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (bus.in_valid),
        .wr_data(wr_cmd),
        .rd_en  (pop),
        .rd_data(rd_cmd),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    assign bus.in_ready    = !full;
    assign bus.fifo_level  = level;
    assign bus.busy        = (state_q != S_IDLE) || !empty;
    assign bus.dac_value   = val_q;
    assign bus.dac_channel = ch_q;
    assign bus.dac_strobe  = stb_q;

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_d     = sx_q;
        sy_d     = sy_q;
        bright_d = bright_q;
        err_d    = err_q;
        dwell_d  = dwell_q;
        val_d    = val_q;
        ch_d     = ch_q;
        stb_d    = 1'b0;
        pop      = 1'b0;

        dx_n = (rd_cmd.x >= cx_q) ? rd_cmd.x - cx_q : cx_q - rd_cmd.x;
        dy_n = (rd_cmd.y >= cy_q) ? rd_cmd.y - cy_q : cy_q - rd_cmd.y;
        e2    = {err_q, 1'b0};
        dxe   = {3'b000, dx_q};
        dye   = {3'b000, dy_q};
        err_w = {err_q[W-1], err_q};

        at_end   = (cx_q == tx_q) && (cy_q == ty_q);
        seg_next = at_end ? ((DWELL > 0) ? S_DWELL : S_IDLE) : S_STEP;
        // One write per ready window; ready may still read high
        // in the cycle right after a strobe.
        can_out  = bus.dac_ready && !stb_q;

        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop      = 1'b1;
                tx_d     = rd_cmd.x;
                ty_d     = rd_cmd.y;
                bright_d = rd_cmd.bright;
                dx_d     = dx_n;
                dy_d     = dy_n;
                sx_d     = rd_cmd.x < cx_q;
                sy_d     = rd_cmd.y < cy_q;
                err_d    = $signed({2'b00, dx_n}) - $signed({2'b00, dy_n});
                // Null segments and 2-channel blanked moves jump to the end.
                if ((dx_n == '0 && dy_n == '0) ||
                    (!rd_cmd.bright && CHANNELS == 2)) begin
                    cx_d    = rd_cmd.x;
                    cy_d    = rd_cmd.y;
                    state_d = S_OUT_X;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                if (e2 > -dye) begin
                    err_w = err_w - dye;
                    cx_d  = sx_q ? cx_q - 1'b1 : cx_q + 1'b1;
                end
                if (e2 < dxe) begin
                    err_w = err_w + dxe;
                    cy_d  = sy_q ? cy_q - 1'b1 : cy_q + 1'b1;
                end
                err_d   = err_w[W-1:0];
                state_d = S_OUT_X;
            end
            S_OUT_X: begin
                if (can_out) begin
                    stb_d   = 1'b1;
                    val_d   = cx_q;
                    ch_d    = CH_X;
                    state_d = S_OUT_Y;
                end
            end
            S_OUT_Y: begin
                if (can_out) begin
                    stb_d   = 1'b1;
                    val_d   = cy_q;
                    ch_d    = CH_Y;
                    dwell_d = '0;
                    state_d = (CHANNELS == 3) ? S_OUT_Z : seg_next;
                end
            end
            S_OUT_Z: begin
                if (can_out) begin
                    stb_d   = 1'b1;
                    val_d   = bright_q ? '1 : '0;
                    ch_d    = CH_Z;
                    state_d = seg_next;
                end
            end
            S_DWELL: begin
                if (dwell_q == 16'(DWELL - 1)) state_d = S_IDLE;
                else dwell_d = dwell_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            tx_q     <= '0;
            ty_q     <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_q     <= 1'b0;
            sy_q     <= 1'b0;
            bright_q <= 1'b0;
            err_q    <= '0;
            dwell_q  <= '0;
            val_q    <= '0;
            ch_q     <= '0;
            stb_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_q     <= sx_d;
            sy_q     <= sy_d;
            bright_q <= bright_d;
            err_q    <= err_d;
            dwell_q  <= dwell_d;
            val_q    <= val_d;
            ch_q     <= ch_d;
            stb_q    <= stb_d;
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench: instance A is 2-channel with a 5-cycle dwell,
// instance B is 3-channel without dwell.
module tb_vector_sequencer;
    import vector_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b;
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    vector_sequencer_if #(.BITS(12), .FIFO_DEPTH(16)) bus_a ();
    vector_sequencer_if #(.BITS(12), .FIFO_DEPTH(16)) bus_b ();

    vector_sequencer #(
        .BITS(12), .FIFO_DEPTH(16), .CHANNELS(2), .DWELL(5)
    ) dut_a (
        .clk(clk), .reset(rst_a), .bus(bus_a)
    );

    vector_sequencer #(
        .BITS(12), .FIFO_DEPTH(16), .CHANNELS(3), .DWELL(0)
    ) dut_b (
        .clk(clk), .reset(rst_b), .bus(bus_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc(input logic [1:0] ch,
                                        input logic [11:0] v);
        return {ch, 2'b00, v};
    endfunction

    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int          t_a[$];
    int          t_b[$];

    // DAC model: ready low for 20 cycles starting one cycle after a strobe.
    // mode 0 = model, 1 = forced low, 2 = forced high.
    int hold_a = 0, hold_b = 0;
    int mode_a = 0, mode_b = 0;

    always @(posedge clk) begin
        if (bus_a.dac_strobe) hold_a <= 20;
        else if (hold_a > 0) hold_a <= hold_a - 1;
        if (bus_b.dac_strobe) hold_b <= 20;
        else if (hold_b > 0) hold_b <= hold_b - 1;
    end

    always_comb begin
        bus_a.dac_ready = (mode_a == 2) || (mode_a == 0 && hold_a == 0);
        bus_b.dac_ready = (mode_b == 2) || (mode_b == 0 && hold_b == 0);
    end

    always @(negedge clk) begin
        if (!rst_a && bus_a.dac_strobe) begin
            t_a.push_back(int'(cyc));
            if (exp_a.size() == 0)
                check("spurious_a", 32'(bus_a.dac_strobe), 32'd0);
            else
                check("dac_a", 32'(enc(bus_a.dac_channel, bus_a.dac_value)),
                      32'(exp_a.pop_front()));
        end
        if (!rst_b && bus_b.dac_strobe) begin
            t_b.push_back(int'(cyc));
            if (exp_b.size() == 0)
                check("spurious_b", 32'(bus_b.dac_strobe), 32'd0);
            else
                check("dac_b", 32'(enc(bus_b.dac_channel, bus_b.dac_value)),
                      32'(exp_b.pop_front()));
        end
    end

    task automatic exp_pt(input int sel, input int x, input int y, input int z);
        if (sel == 0) begin
            exp_a.push_back(enc(CH_X, 12'(x)));
            exp_a.push_back(enc(CH_Y, 12'(y)));
        end else begin
            exp_b.push_back(enc(CH_X, 12'(x)));
            exp_b.push_back(enc(CH_Y, 12'(y)));
            exp_b.push_back(enc(CH_Z, 12'(z)));
        end
    endtask

    task automatic push(input int sel, input int x, input int y,
                        input bit b, output bit acc);
        @(negedge clk);
        if (sel == 0) begin
            bus_a.in_valid  = 1'b1;
            bus_a.in_x      = 12'(x);
            bus_a.in_y      = 12'(y);
            bus_a.in_bright = b;
            acc = bus_a.in_ready;
        end else begin
            bus_b.in_valid  = 1'b1;
            bus_b.in_x      = 12'(x);
            bus_b.in_y      = 12'(y);
            bus_b.in_bright = b;
            acc = bus_b.in_ready;
        end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
    endtask

    task automatic drain(input int sel, input int limit);
        int n = 0;
        if (sel == 0)
            while ((bus_a.busy || exp_a.size() != 0) && n < limit) begin
                @(negedge clk);
                n++;
            end
        else
            while ((bus_b.busy || exp_b.size() != 0) && n < limit) begin
                @(negedge clk);
                n++;
            end
        check(sel == 0 ? "drain_tmo_a" : "drain_tmo_b", 32'(n >= limit), 32'd0);
    endtask

    task automatic reset_dut(input int sel);
        @(negedge clk);
        if (sel == 0) begin
            rst_a = 1'b1;
            exp_a.delete();
        end else begin
            rst_b = 1'b1;
            exp_b.delete();
        end
        @(negedge clk);
        if (sel == 0) begin
            check("rst_strobe_a", 32'(bus_a.dac_strobe), 32'd0);
            check("rst_level_a", 32'(bus_a.fifo_level), 32'd0);
            check("rst_busy_a", 32'(bus_a.busy), 32'd0);
            check("rst_ready_a", 32'(bus_a.in_ready), 32'd1);
            check("rst_value_a", 32'(bus_a.dac_value), 32'd0);
            check("rst_chan_a", 32'(bus_a.dac_channel), 32'd0);
            rst_a = 1'b0;
        end else begin
            check("rst_strobe_b", 32'(bus_b.dac_strobe), 32'd0);
            check("rst_level_b", 32'(bus_b.fifo_level), 32'd0);
            check("rst_busy_b", 32'(bus_b.busy), 32'd0);
            check("rst_ready_b", 32'(bus_b.in_ready), 32'd1);
            check("rst_value_b", 32'(bus_b.dac_value), 32'd0);
            check("rst_chan_b", 32'(bus_b.dac_channel), 32'd0);
            rst_b = 1'b0;
        end
    endtask

    initial begin
        bit acc;
        int n;
        int tries;
        int gap_a, gap_b;

        rst_a = 1'b1;
        rst_b = 1'b1;
        bus_a.in_valid = 1'b0;
        bus_a.in_x = '0;
        bus_a.in_y = '0;
        bus_a.in_bright = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_b.in_x = '0;
        bus_b.in_y = '0;
        bus_b.in_bright = 1'b0;
        repeat (2) @(negedge clk);
        reset_dut(0);
        reset_dut(1);

        // Drawn line to (3,1).
        push(0, 3, 1, 1'b1, acc);
        check("acc_t1", 32'(acc), 32'd1);
        exp_pt(0, 1, 0, 0);
        exp_pt(0, 2, 1, 0);
        exp_pt(0, 3, 1, 0);
        drain(0, 1000);
        check("hold_value", 32'(bus_a.dac_value), 32'd1);
        check("hold_chan", 32'(bus_a.dac_channel), 32'(CH_Y));

        // Zero-length segment after reset.
        reset_dut(0);
        push(0, 0, 0, 1'b1, acc);
        exp_pt(0, 0, 0, 0);
        drain(0, 1000);
        check("busy_clear", 32'(bus_a.busy), 32'd0);

        // Blanked jump on the 2-channel instance.
        push(0, 100, 50, 1'b0, acc);
        exp_pt(0, 100, 50, 0);
        drain(0, 1000);

        // Fill with the DAC stalled; the engine takes one entry out.
        mode_a = 1;
        n = 0;
        tries = 0;
        while (bus_a.in_ready && tries < 20) begin
            push(0, 100, 50, 1'b1, acc);
            tries++;
            if (acc) begin
                n++;
                exp_pt(0, 100, 50, 0);
            end
        end
        check("full_level", 32'(bus_a.fifo_level), 32'd16);
        check("full_ready", 32'(bus_a.in_ready), 32'd0);
        check("full_count", 32'(n), 32'd17);
        push(0, 5, 5, 1'b1, acc);
        check("full_push", 32'(acc), 32'd0);
        check("full_level2", 32'(bus_a.fifo_level), 32'd16);
        mode_a = 0;
        drain(0, 5000);

        // Reset in the middle of a 10-point diagonal.
        t_a.delete();
        push(0, 110, 60, 1'b1, acc);
        for (int k = 1; k <= 10; k++) exp_pt(0, 100 + k, 50 + k, 0);
        push(0, 120, 70, 1'b1, acc);
        n = 0;
        while (t_a.size() < 5 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("mid_tmo", 32'(n >= 500), 32'd0);
        repeat (2) @(negedge clk);
        reset_dut(0);
        push(0, 2, 0, 1'b1, acc);
        exp_pt(0, 1, 0, 0);
        exp_pt(0, 2, 0, 0);
        drain(0, 1000);

        // Z channel: blanked then drawn.
        push(1, 0, 2, 1'b0, acc);
        exp_pt(1, 0, 1, 0);
        exp_pt(1, 0, 2, 0);
        push(1, 2, 2, 1'b1, acc);
        exp_pt(1, 1, 2, 12'hFFF);
        exp_pt(1, 2, 2, 12'hFFF);
        drain(1, 2000);

        // Dwell: same two-segment job on both, DAC always ready.
        mode_a = 2;
        mode_b = 2;
        t_a.delete();
        t_b.delete();
        push(0, 3, 0, 1'b1, acc);
        exp_pt(0, 3, 0, 0);
        push(0, 4, 0, 1'b1, acc);
        exp_pt(0, 4, 0, 0);
        push(1, 3, 2, 1'b1, acc);
        exp_pt(1, 3, 2, 12'hFFF);
        push(1, 4, 2, 1'b1, acc);
        exp_pt(1, 4, 2, 12'hFFF);
        drain(0, 1000);
        drain(1, 1000);
        check("dwell_na", 32'(t_a.size()), 32'd4);
        check("dwell_nb", 32'(t_b.size()), 32'd6);
        if (t_a.size() == 4 && t_b.size() == 6) begin
            gap_a = t_a[2] - t_a[1];
            gap_b = t_b[3] - t_b[2];
            check("dwell_gap", 32'(gap_a), 32'(gap_b + 5));
        end
        mode_a = 0;
        mode_b = 0;

        repeat (30) @(negedge clk);
        check("left_a", 32'(exp_a.size()), 32'd0);
        check("left_b", 32'(exp_b.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
